// File: rtl/cpu_seq_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, decoded-control
// register layout and parameter defaults.
package cpu_seq_pkg;

    localparam int INSTR_W_DEF     = 12;
    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } seqState_e;

    typedef struct packed {
        logic memRd;
        logic memWr;
        logic regWr;
        logic pcInc;
    } ctrl_t;

    function automatic logic ctrlNeedsMem(input ctrl_t c);
        return c.memRd | c.memWr;
    endfunction

    // A store never writes back to the register file, even if regWr is decoded.
    function automatic logic ctrlRegWe(input ctrl_t c);
        return c.regWr & ~c.memWr;
    endfunction

endpackage

// File: rtl/seq_step_edge.sv
// Board step switch: two-flop synchronizer, rising-edge detect and a pending
// latch that holds the request until the sequencer leaves IDLE.
module seq_step_edge (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic step_i,
    input  logic run_i,
    input  logic consume_i,
    output logic pending_o
);

    logic [2:0] sync_q;
    logic       pending_q;
    logic       pending_d;
    logic       stepEdge;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], step_i};
        end
    end

    assign stepEdge = sync_q[1] & ~sync_q[2];

    // A fresh edge beats a same-cycle consume so a rapid second press is kept.
    always_comb begin
        pending_d = pending_q;
        if (consume_i) begin
            pending_d = 1'b0;
        end
        if (stepEdge && !run_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit datapath.
// Define SEQ_TIMEOUT_EN to bound every ack wait and trap into FAULT on expiry.
module cpu_cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               run_i,
    input  logic               step_i,
    output logic               fetch_req_o,
    input  logic               fetch_ack_i,
    input  logic [DATA_W-1:0]  fetch_data_i,
    output logic [INSTR_W-1:0] instr_o,
    input  logic               dec_mem_rd_i,
    input  logic               dec_mem_wr_i,
    input  logic               dec_reg_wr_i,
    input  logic               dec_pc_inc_i,
    output logic               data_req_o,
    output logic               data_we_o,
    input  logic               data_ack_i,
    output logic               alu_en_o,
    output logic               reg_we_o,
    output logic               pc_inc_o,
    output logic               pc_load_o,
    output logic               halted_o,
    output logic               fault_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYC - 1);

    seqState_e          state_q;
    seqState_e          state_d;
    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic               stepPending;
    logic               stepConsume;
    logic               waitExpired;
    logic [DATA_W-INSTR_W-1:0] unusedFetchHi;

    assign unusedFetchHi = fetch_data_i[DATA_W-1:INSTR_W];

    seq_step_edge u_step_edge (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .step_i    (step_i),
        .run_i     (run_i),
        .consume_i (stepConsume),
        .pending_o (stepPending)
    );

`ifdef SEQ_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] waitCnt_q;
    logic [WAIT_CNT_W-1:0] waitCnt_d;

    // Any state other than an unacked FETCH/MEM cycle clears the count, so
    // each entry into a wait state starts from zero.
    always_comb begin
        waitCnt_d = '0;
        if ((state_q == ST_FETCH && !fetch_ack_i) || (state_q == ST_MEM && !data_ack_i)) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    assign waitExpired = (waitCnt_q == WAIT_LIMIT);
`else
    logic [WAIT_CNT_W-1:0] unusedWaitLimit;

    assign unusedWaitLimit = WAIT_LIMIT;
    assign waitExpired     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i || stepPending) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_ack_i) begin
                    state_d = ST_DECODE;
                end else if (waitExpired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ctrlNeedsMem(ctrl_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (data_ack_i) begin
                    state_d = ST_WB;
                end else if (waitExpired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB:    state_d = run_i ? ST_FETCH : ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign stepConsume = (state_q == ST_IDLE) && (state_d == ST_FETCH);

    // The instruction register only moves on an acked fetch; the control bits
    // are captured at the end of the single DECODE cycle.
    always_comb begin
        instr_d = instr_q;
        ctrl_d  = ctrl_q;
        if (state_q == ST_FETCH && fetch_ack_i) begin
            instr_d = fetch_data_i[INSTR_W-1:0];
        end
        if (state_q == ST_DECODE) begin
            ctrl_d.memRd = dec_mem_rd_i;
            ctrl_d.memWr = dec_mem_wr_i;
            ctrl_d.regWr = dec_reg_wr_i;
            ctrl_d.pcInc = dec_pc_inc_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            instr_q <= '0;
            ctrl_q  <= '0;
        end else begin
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign instr_o = instr_q;

    // Outputs decode straight from state so an async reset drops requests at once.
    always_comb begin
        fetch_req_o = 1'b0;
        data_req_o  = 1'b0;
        data_we_o   = 1'b0;
        alu_en_o    = 1'b0;
        reg_we_o    = 1'b0;
        pc_inc_o    = 1'b0;
        pc_load_o   = 1'b0;
        halted_o    = 1'b0;
        fault_o     = 1'b0;
        case (state_q)
            ST_IDLE:  halted_o    = 1'b1;
            ST_FETCH: fetch_req_o = 1'b1;
            ST_EXEC:  alu_en_o    = 1'b1;
            ST_MEM: begin
                data_req_o = 1'b1;
                data_we_o  = ctrl_q.memWr;
            end
            ST_WB: begin
                reg_we_o  = ctrlRegWe(ctrl_q);
                pc_inc_o  = ctrl_q.pcInc;
                pc_load_o = ~ctrl_q.pcInc;
            end
            ST_FAULT: begin
                halted_o = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                fault_o  = 1'b1;
`endif
            end
            default: halted_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: table vectors, hand-written
// halt/step/reset sequences and random instructions against an instruction-level model.
module tb_cpu_cycle_sequencer;

   logic        clk = 1'b0;
   logic        resetN;
   logic        run;
   logic        step;
   logic        fetchReq;
   logic        fetchAck;
   logic [15:0] fetchData;
   logic [11:0] instr;
   logic        decMemRd;
   logic        decMemWr;
   logic        decRegWr;
   logic        decPcInc;
   logic        dataReq;
   logic        dataWe;
   logic        dataAck;
   logic        aluEn;
   logic        regWe;
   logic        pcInc;
   logic        pcLoad;
   logic        halted;
   logic        fault;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        memRd;
      logic        memWr;
      logic        regWr;
      logic        pcInc;
      logic [15:0] data;
      int          fetchWait;
      int          dataWait;
      int          expCycles;
      int          expRegWe;
      int          expPcInc;
      int          expPcLoad;
      int          expDataReq;
      int          expDataWe;
      logic [11:0] expInstr;
   } instrVec_t;

`ifdef SEQ_TIMEOUT_EN
   localparam int TbTimeoutCyc = 4;
`else
   localparam int TbTimeoutCyc = 255;
`endif

   always #5 clk = ~clk;

   cpu_cycle_sequencer #(.TIMEOUT_CYC(TbTimeoutCyc)) dut (
      .clk_i        (clk),
      .reset_n_i    (resetN),
      .run_i        (run),
      .step_i       (step),
      .fetch_req_o  (fetchReq),
      .fetch_ack_i  (fetchAck),
      .fetch_data_i (fetchData),
      .instr_o      (instr),
      .dec_mem_rd_i (decMemRd),
      .dec_mem_wr_i (decMemWr),
      .dec_reg_wr_i (decRegWr),
      .dec_pc_inc_i (decPcInc),
      .data_req_o   (dataReq),
      .data_we_o    (dataWe),
      .data_ack_i   (dataAck),
      .alu_en_o     (aluEn),
      .reg_we_o     (regWe),
      .pc_inc_o     (pcInc),
      .pc_load_o    (pcLoad),
      .halted_o     (halted),
      .fault_o      (fault)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   function automatic logic [8:0] outVec();
      return {fetchReq, dataReq, dataWe, aluEn, regWe, pcInc, pcLoad, halted, fault};
   endfunction

   // Instruction-level reference: every instruction costs fetch + decode + exec
   // + writeback cycles, plus one cycle per ack wait and a memory phase if it touches memory.
   function automatic instrVec_t model(input instrVec_t v);
      instrVec_t r;
      int        memCycles;
      r          = v;
      memCycles  = (v.memRd || v.memWr) ? 1 + v.dataWait : 0;
      r.expCycles  = (1 + v.fetchWait) + 1 + 1 + memCycles + 1;
      r.expRegWe   = (v.regWr && !v.memWr) ? 1 : 0;
      r.expPcInc   = v.pcInc ? 1 : 0;
      r.expPcLoad  = v.pcInc ? 0 : 1;
      r.expDataReq = memCycles;
      r.expDataWe  = v.memWr ? memCycles : 0;
      r.expInstr   = v.data[11:0];
      return r;
   endfunction

   // Runs one instruction from its first FETCH cycle through WB, acting as the
   // memory system, then checks strobe counts, latency and where the FSM went next.
   task automatic applyStimulus(input instrVec_t v, input bit dropRun);
      int          waitCycles = 0;
      int          cycles = 0;
      int          fwLeft = v.fetchWait;
      int          dwLeft = v.dataWait;
      int          nAlu = 0, nRegWe = 0, nPcInc = 0, nPcLoad = 0;
      int          nDataReq = 0, nDataWe = 0, nHalted = 0, nFault = 0;
      bit          seenWb = 1'b0;
      logic        runAtWb = 1'b0;
      logic [11:0] gotInstr = '0;

      decMemRd = v.memRd;
      decMemWr = v.memWr;
      decRegWr = v.regWr;
      decPcInc = v.pcInc;
      while (!fetchReq && waitCycles < 30) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("fetchStart", fetchReq, 1'b1);

      while (!seenWb && cycles < 200) begin
         cycles++;
         if (halted) nHalted++;
         if (fault) nFault++;
         if (fetchReq) begin
            fetchAck = (fwLeft == 0);
            fetchData = fetchAck ? v.data : 16'($urandom);
            if (fwLeft > 0) fwLeft--;
         end else begin
            fetchAck  = 1'($urandom_range(0, 1));
            fetchData = 16'($urandom);
         end
         if (dataReq) begin
            nDataReq++;
            if (dataWe) nDataWe++;
            dataAck = (dwLeft == 0);
            if (dwLeft > 0) dwLeft--;
         end else begin
            dataAck = 1'($urandom_range(0, 1));
         end
         if (aluEn) begin
            nAlu++;
            if (dropRun) run = 1'b0;
         end
         if (regWe) nRegWe++;
         if (pcInc) nPcInc++;
         if (pcLoad) nPcLoad++;
         if (pcInc || pcLoad) begin
            seenWb   = 1'b1;
            gotInstr = instr;
            runAtWb  = run;
         end
         @(negedge clk);
      end

      checkOutput("wbReached", seenWb, 1'b1);
      checkOutput("cycles", cycles, v.expCycles);
      checkOutput("aluEnPulses", nAlu, 1);
      checkOutput("regWePulses", nRegWe, v.expRegWe);
      checkOutput("pcIncPulses", nPcInc, v.expPcInc);
      checkOutput("pcLoadPulses", nPcLoad, v.expPcLoad);
      checkOutput("dataReqCycles", nDataReq, v.expDataReq);
      checkOutput("dataWeCycles", nDataWe, v.expDataWe);
      checkOutput("instr", gotInstr, v.expInstr);
      checkOutput("haltedOrFaultDuringInstr", nHalted + nFault, 0);
      checkOutput("nextState", {fetchReq, halted}, runAtWb ? 2'b10 : 2'b01);
   endtask

   task automatic idleCycles(input int n, output int fetchSeen, output int haltedSeen);
      fetchSeen  = 0;
      haltedSeen = 0;
      repeat (n) begin
         @(negedge clk);
         if (fetchReq) fetchSeen++;
         if (halted) haltedSeen++;
      end
   endtask

   instrVec_t vectors[7];
   instrVec_t rv;

   initial begin
      int fetchSeen;
      int haltedSeen;
      int waitCycles;

      resetN = 1'b0; run = 1'b0; step = 1'b0;
      fetchAck = 1'b0; dataAck = 1'b0; fetchData = '0;
      decMemRd = 1'b0; decMemWr = 1'b0; decRegWr = 1'b0; decPcInc = 1'b0;

      //              rd    wr    reg   inc   data      fw dw cyc reg inc ld dreq dwe instr
      vectors[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 0, 0, 4,  1,  1,  0, 0,   0,  12'h123};
      vectors[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hA5F0, 0, 3, 8,  0,  1,  0, 4,   4,  12'h5F0};
      vectors[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hF7FF, 0, 0, 4,  0,  0,  1, 0,   0,  12'h7FF};
      vectors[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1ABC, 2, 1, 8,  1,  1,  0, 2,   0,  12'hABC};
      vectors[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0FFF, 1, 0, 6,  0,  0,  1, 1,   1,  12'hFFF};
      vectors[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 3, 0, 7,  0,  1,  0, 0,   0,  12'h000};
      vectors[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 3, 3, 11, 1,  0,  1, 4,   0,  12'h321};

      repeat (3) @(negedge clk);
      checkOutput("resetOutputs", outVec(), 9'b0000_0001_0);
      checkOutput("resetInstr", instr, 12'h000);
      resetN = 1'b1;
      idleCycles(3, fetchSeen, haltedSeen);
      checkOutput("idleAfterReset", {fetchSeen[7:0], haltedSeen[7:0]}, {8'd0, 8'd3});

      $display("[TB] table vectors");
      run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i], 1'b0);
      end

      $display("[TB] async reset during MEM");
      decMemRd = 1'b0; decMemWr = 1'b1; decRegWr = 1'b0; decPcInc = 1'b1;
      fetchAck = 1'b1; fetchData = 16'h0ABC; dataAck = 1'b0;
      waitCycles = 0;
      while (!dataReq && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("memReqSeen", {dataReq, dataWe}, 2'b11);
      #2 resetN = 1'b0;
      #1 checkOutput("asyncDropDataReq", dataReq, 1'b0);
      checkOutput("asyncClearInstr", instr, 12'h000);
      run = 1'b0; fetchAck = 1'b0; dataAck = 1'b0;
      @(negedge clk);
      checkOutput("resetDuringMem", outVec(), 9'b0000_0001_0);
      resetN = 1'b1;

      $display("[TB] halt in EXEC then single step");
      run = 1'b1;
      applyStimulus(vectors[0], 1'b1);
      idleCycles(5, fetchSeen, haltedSeen);
      checkOutput("haltedIdle", {fetchSeen[7:0], haltedSeen[7:0]}, {8'd0, 8'd5});
      step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      applyStimulus(vectors[3], 1'b0);
      idleCycles(8, fetchSeen, haltedSeen);
      checkOutput("singleStepOnly", {fetchSeen[7:0], haltedSeen[7:0]}, {8'd0, 8'd8});

      $display("[TB] step edge while running is discarded");
      run = 1'b1; step = 1'b1;
      applyStimulus(vectors[2], 1'b0);
      step = 1'b0;
      applyStimulus(vectors[0], 1'b1);
      idleCycles(8, fetchSeen, haltedSeen);
      checkOutput("stepDiscarded", {fetchSeen[7:0], haltedSeen[7:0]}, {8'd0, 8'd8});

      $display("[TB] random instructions");
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rv.memRd     = 1'($urandom_range(0, 1));
         rv.memWr     = 1'($urandom_range(0, 1));
         rv.regWr     = 1'($urandom_range(0, 1));
         rv.pcInc     = 1'($urandom_range(0, 1));
         rv.data      = 16'($urandom);
         rv.fetchWait = $urandom_range(0, 3);
         rv.dataWait  = $urandom_range(0, 3);
         applyStimulus(model(rv), i == 39);
      end

`ifdef SEQ_TIMEOUT_EN
      $display("[TB] fetch timeout");
      resetN = 1'b0; fetchAck = 1'b0; dataAck = 1'b0; run = 1'b1;
      @(negedge clk);
      resetN = 1'b1;
      waitCycles = 0;
      while (!fetchReq && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      fetchSeen = 0;
      while (fetchReq && fetchSeen < 20) begin
         fetchSeen++;
         @(negedge clk);
      end
      checkOutput("timeoutWaitCycles", fetchSeen, 4);
      checkOutput("faultState", outVec(), 9'b0000_0001_1);
      fetchAck = 1'b1; dataAck = 1'b1; step = 1'b1;
      repeat (3) @(negedge clk);
      run = 1'b0; step = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("faultSticky", outVec(), 9'b0000_0001_1);
      resetN = 1'b0;
      #1 checkOutput("faultClearedByReset", fault, 1'b0);
      @(negedge clk);
      resetN = 1'b1;
      fetchAck = 1'b0; dataAck = 1'b0;
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
